// File: rtl/rf_writeback_queue.sv
// Register-file write-port arbiter: in-order pipeline writes take priority over a
// small FIFO of long-latency writes; exports pending-write hazard flags for decode.
module rf_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          pipe_wen,
  input  logic [4:0]    pipe_wsel,
  input  logic [31:0]   pipe_wdat,
  input  logic          lu_valid,
  output logic          lu_ready,
  input  logic [4:0]    lu_wsel,
  input  logic [31:0]   lu_wdat,
  output logic          rf_wen,
  output logic [4:0]    rf_wsel,
  output logic [31:0]   rf_wdat,
  input  logic [4:0]    rsel1,
  input  logic [4:0]    rsel2,
  output logic          pend1,
  output logic          pend2,
  output logic          pendw,
  output logic [CW-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [4:0]    ent_wsel_r [DEPTH];
  logic [31:0]   ent_wdat_r [DEPTH];
  logic [DEPTH-1:0] ent_vld_r;
  logic [AW-1:0] head_r;
  logic [AW-1:0] tail_r;
  logic [CW-1:0] count_r;
  logic          rf_wen_r;
  logic [4:0]    rf_wsel_r;
  logic [31:0]   rf_wdat_r;

  logic          pipe_issue_s;
  logic          push_s;
  logic          pop_s;
  logic          issue_s;
  logic [4:0]    nxt_wsel_s;
  logic [31:0]   nxt_wdat_s;
  logic          hit1_s;
  logic          hit2_s;
  logic          hitw_s;

  assign lu_ready = (count_r < CW'(DEPTH));
  assign count    = count_r;
  assign rf_wen   = rf_wen_r;
  assign rf_wsel  = rf_wsel_r;
  assign rf_wdat  = rf_wdat_r;

  // Write-port selection: a live pipeline write wins; $0 writes never occupy the port or the queue.
  always_comb begin
    pipe_issue_s = pipe_wen && (pipe_wsel != 5'd0);
    push_s       = lu_valid && lu_ready && (lu_wsel != 5'd0);
    pop_s        = !pipe_issue_s && (count_r != CW'(0));
    issue_s      = pipe_issue_s || pop_s;
    nxt_wsel_s   = rf_wsel_r;
    nxt_wdat_s   = rf_wdat_r;
    if (pipe_issue_s) begin
      nxt_wsel_s = pipe_wsel;
      nxt_wdat_s = pipe_wdat;
    end else if (pop_s) begin
      nxt_wsel_s = ent_wsel_r[head_r];
      nxt_wdat_s = ent_wdat_r[head_r];
    end else begin
      nxt_wsel_s = rf_wsel_r;
      nxt_wdat_s = rf_wdat_r;
    end
  end

  // Hazard match of decode selects and the pipeline destination against queued entries.
  always_comb begin
    hit1_s = 1'b0;
    hit2_s = 1'b0;
    hitw_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld_r[i]) begin
        hit1_s = hit1_s || (ent_wsel_r[i] == rsel1);
        hit2_s = hit2_s || (ent_wsel_r[i] == rsel2);
        hitw_s = hitw_s || (ent_wsel_r[i] == pipe_wsel);
      end else begin
        hit1_s = hit1_s;
        hit2_s = hit2_s;
        hitw_s = hitw_s;
      end
    end
    pend1 = (rsel1 != 5'd0) && (hit1_s || (rf_wen_r && (rf_wsel_r == rsel1)));
    pend2 = (rsel2 != 5'd0) && (hit2_s || (rf_wen_r && (rf_wsel_r == rsel2)));
    pendw = (pipe_wsel != 5'd0) && hitw_s;
  end

  // Queue control state and registered write port.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      ent_vld_r <= '0;
      head_r    <= '0;
      tail_r    <= '0;
      count_r   <= '0;
      rf_wen_r  <= 1'b0;
      rf_wsel_r <= 5'd0;
      rf_wdat_r <= 32'd0;
    end else begin
      rf_wen_r  <= issue_s;
      rf_wsel_r <= nxt_wsel_s;
      rf_wdat_r <= nxt_wdat_s;
      // Clear before set: at count==1 with push+pop the tail slot differs from head.
      if (pop_s) begin
        ent_vld_r[head_r] <= 1'b0;
        head_r            <= head_r + AW'(1);
      end
      if (push_s) begin
        ent_vld_r[tail_r] <= 1'b1;
        tail_r            <= tail_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry payload storage; only meaningful where the matching valid bit is set.
  always_ff @(posedge CLK) begin
    if (push_s) begin
      ent_wsel_r[tail_r] <= lu_wsel;
      ent_wdat_r[tail_r] <= lu_wdat;
    end
  end

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Directed self-checking bench for rf_writeback_queue (DEPTH=4).
module tb_rf_writeback_queue;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        pipe_wen;
  logic [4:0]  pipe_wsel;
  logic [31:0] pipe_wdat;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_wsel;
  logic [31:0] lu_wdat;
  logic        rf_wen;
  logic [4:0]  rf_wsel;
  logic [31:0] rf_wdat;
  logic [4:0]  rsel1;
  logic [4:0]  rsel2;
  logic        pend1;
  logic        pend2;
  logic        pendw;
  logic [2:0]  count;

  int n_cmp  = 0;
  int n_fail = 0;

  rf_writeback_queue #(.DEPTH(4), .CW(3)) dut (
    .CLK(CLK), .nRST(nRST),
    .pipe_wen(pipe_wen), .pipe_wsel(pipe_wsel), .pipe_wdat(pipe_wdat),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_wsel(lu_wsel), .lu_wdat(lu_wdat),
    .rf_wen(rf_wen), .rf_wsel(rf_wsel), .rf_wdat(rf_wdat),
    .rsel1(rsel1), .rsel2(rsel2),
    .pend1(pend1), .pend2(pend2), .pendw(pendw), .count(count)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    nRST = 1'b0; pipe_wen = 1'b0; pipe_wsel = 5'd0; pipe_wdat = 32'd0;
    lu_valid = 1'b0; lu_wsel = 5'd0; lu_wdat = 32'd0; rsel1 = 5'd8; rsel2 = 5'd5;
    step();
    chk("rst_rf_wen", 32'(rf_wen), 32'd0);
    chk("rst_rf_wsel", 32'(rf_wsel), 32'd0);
    chk("rst_rf_wdat", rf_wdat, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_lu_ready", 32'(lu_ready), 32'd1);
    chk("rst_pend", {29'd0, pend1, pend2, pendw}, 32'd0);
    nRST = 1'b1;

    // pipeline only
    pipe_wen = 1'b1; pipe_wsel = 5'd5; pipe_wdat = 32'hDEADBEEF;
    step();
    chk("pipe_wen", 32'(rf_wen), 32'd1);
    chk("pipe_wsel", 32'(rf_wsel), 32'd5);
    chk("pipe_wdat", rf_wdat, 32'hDEADBEEF);
    chk("pipe_pend2_port", 32'(pend2), 32'd1);
    pipe_wsel = 5'd0;
    step();
    chk("pipe_r0_wen", 32'(rf_wen), 32'd0);
    chk("pipe_r0_hold_wsel", 32'(rf_wsel), 32'd5);

    // priority and drain
    pipe_wsel = 5'd3; pipe_wdat = 32'h33;
    lu_valid = 1'b1; lu_wsel = 5'd8; lu_wdat = 32'h11;
    step();
    lu_wsel = 5'd9; lu_wdat = 32'h22;
    step();
    lu_valid = 1'b0;
    step();
    chk("prio_wsel", 32'(rf_wsel), 32'd3);
    chk("prio_wdat", rf_wdat, 32'h33);
    chk("prio_count", 32'(count), 32'd2);
    chk("prio_pend1", 32'(pend1), 32'd1);
    pipe_wen = 1'b0;
    step();
    chk("drain0_wsel", 32'(rf_wsel), 32'd8);
    chk("drain0_wdat", rf_wdat, 32'h11);
    chk("drain0_count", 32'(count), 32'd1);
    step();
    chk("drain1_wen", 32'(rf_wen), 32'd1);
    chk("drain1_wsel", 32'(rf_wsel), 32'd9);
    chk("drain1_wdat", rf_wdat, 32'h22);
    chk("drain1_count", 32'(count), 32'd0);
    step();
    chk("drain_idle_wen", 32'(rf_wen), 32'd0);
    chk("drain_idle_pend1", 32'(pend1), 32'd0);

    // full boundary
    pipe_wen = 1'b1; pipe_wsel = 5'd3;
    lu_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      lu_wsel = 5'(16 + i); lu_wdat = 32'hA0 + 32'(i);
      step();
    end
    chk("full_count", 32'(count), 32'd4);
    chk("full_ready", 32'(lu_ready), 32'd0);
    lu_wsel = 5'd20; lu_wdat = 32'hA4;
    step();
    chk("full_hold_count", 32'(count), 32'd4);
    chk("full_hold_ready", 32'(lu_ready), 32'd0);
    pipe_wen = 1'b0;
    step();
    chk("full_pop_wsel", 32'(rf_wsel), 32'd16);
    chk("full_pop_wdat", rf_wdat, 32'hA0);
    chk("full_pop_count", 32'(count), 32'd3);
    chk("full_pop_ready", 32'(lu_ready), 32'd1);
    step();
    lu_valid = 1'b0;
    chk("full_xfer_count", 32'(count), 32'd3);
    chk("full_xfer_wsel", 32'(rf_wsel), 32'd17);
    for (int i = 2; i < 5; i++) begin
      step();
      chk("full_drain_wsel", 32'(rf_wsel), 32'(16 + i));
      chk("full_drain_wdat", rf_wdat, 32'hA0 + 32'(i));
    end
    chk("full_drain_count", 32'(count), 32'd0);
    step();

    // wrap-around with push+pop at count==1
    lu_valid = 1'b1; lu_wsel = 5'd7; lu_wdat = 32'h100;
    step();
    chk("wrap_first_count", 32'(count), 32'd1);
    for (int i = 1; i < 10; i++) begin
      lu_wdat = 32'h100 + 32'(i);
      step();
      chk("wrap_wdat", rf_wdat, 32'h100 + 32'(i - 1));
      chk("wrap_count", 32'(count), 32'd1);
    end
    lu_valid = 1'b0;
    step();
    chk("wrap_last_wdat", rf_wdat, 32'h109);
    chk("wrap_last_count", 32'(count), 32'd0);

    // lu write to $0 completes but is not queued
    lu_valid = 1'b1; lu_wsel = 5'd0; lu_wdat = 32'h55;
    step();
    lu_valid = 1'b0;
    chk("lu_r0_count", 32'(count), 32'd0);
    step();
    chk("lu_r0_wen", 32'(rf_wen), 32'd0);

    // pipeline write to $0 does not block a pop
    lu_valid = 1'b1; lu_wsel = 5'd21; lu_wdat = 32'h21;
    step();
    lu_valid = 1'b0; pipe_wen = 1'b1; pipe_wsel = 5'd0;
    step();
    chk("pipe_r0_pop_wsel", 32'(rf_wsel), 32'd21);
    chk("pipe_r0_pop_count", 32'(count), 32'd0);
    pipe_wen = 1'b0;
    step();

    // WAW flag, then reset mid-operation
    pipe_wen = 1'b1; pipe_wsel = 5'd4;
    lu_valid = 1'b1; lu_wsel = 5'd12; lu_wdat = 32'h12C;
    step();
    chk("waw_pendw_nomatch", 32'(pendw), 32'd0);
    pipe_wsel = 5'd12;
    lu_wsel = 5'd13; lu_wdat = 32'h13D;
    #1;
    chk("waw_pendw", 32'(pendw), 32'd1);
    step();
    lu_wsel = 5'd14; lu_wdat = 32'h14E;
    step();
    lu_valid = 1'b0;
    chk("waw_count", 32'(count), 32'd3);
    nRST = 1'b0; pipe_wen = 1'b0;
    step();
    chk("mrst_count", 32'(count), 32'd0);
    chk("mrst_wen", 32'(rf_wen), 32'd0);
    chk("mrst_pendw", 32'(pendw), 32'd0);
    nRST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mrst_no_write", 32'(rf_wen), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_writeback_queue.md
Name: rf_writeback_queue

Overview:
- Sits directly upstream of the register file and drives its single write port (WEN/wsel/wdat).
- Merges two write sources:
  - the in-order pipeline writeback, which takes priority and is never stalled;
  - a long-latency unit (multiply/divide, cache-miss load) via valid/ready into a small FIFO.
- Issues at most one register write per cycle.
- Exports pending-write hazard flags so the decode stage can stall RAW/WAW on queued writes.

Parameters:
- DEPTH, 4, number of FIFO entries for long-latency writes; power of two, 2..16.
- CW, 3, width of the count output; must equal log2(DEPTH)+1.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- nRST  in  1  reset, synchronous, active-low.
- pipe_wen  in  1  pipeline writeback request this cycle.
- pipe_wsel  in  5  pipeline destination register.
- pipe_wdat  in  32  pipeline write data.
- lu_valid  in  1  long-latency unit offers a write.
- lu_ready  out  1  queue accepts the offered write this cycle.
- lu_wsel  in  5  long-latency destination register.
- lu_wdat  in  32  long-latency write data.
- rf_wen  out  1  register file write enable.
- rf_wsel  out  5  register file write select.
- rf_wdat  out  32  register file write data.
- rsel1  in  5  decode read select 1, for hazard check.
- rsel2  in  5  decode read select 2, for hazard check.
- pend1  out  1  rsel1 has an outstanding write.
- pend2  out  1  rsel2 has an outstanding write.
- pendw  out  1  pipe_wsel matches a queued FIFO entry (WAW).
- count  out  CW  number of valid FIFO entries.

Behaviour:
- Reset:
  - nRST low at a rising edge clears the FIFO: count=0, head/tail pointers=0, all entry valids=0.
  - Output register cleared: rf_wen=0, rf_wsel=0, rf_wdat=0.
  - Reset mid-operation discards queued writes; no partial write is issued.
- Clock and reset: one clock, CLK; reset is synchronous and active-low on nRST.
- Output stage:
  - rf_wen/rf_wsel/rf_wdat are registered.
  - A write selected in cycle t appears on the rf_* ports in cycle t+1.
  - The register file commits it at the end of t+1.
- Selection in cycle t, evaluated in order:
  1. pipe_wen=1 and pipe_wsel!=0: issue the pipeline write; the FIFO does not pop.
  2. Otherwise, FIFO non-empty: issue the head entry and pop.
  3. Otherwise: rf_wen=0 next cycle. rf_wsel/rf_wdat hold their previous values.
- Register $0:
  - A pipeline write to register 0 is dropped and does not block a FIFO pop.
  - An lu write to register 0 is accepted (handshake completes) but not enqueued.
- Handshake:
  - lu_ready = (count < DEPTH), registered-state based only; it does not depend on a same-cycle pop.
  - Transfer occurs when lu_valid && lu_ready at the rising edge.
  - lu_wsel/lu_wdat must be held stable while lu_valid=1 and lu_ready=0.
- FIFO:
  - Circular buffer; pointers wrap modulo DEPTH.
  - Push and pop in the same cycle leave count unchanged.
  - When count==1, a simultaneous push and pop is legal; the new entry becomes the head.
  - Order is preserved among lu writes.
- Hazard flags, combinational:
  - pend1 = rsel1!=0 && (rsel1 matches any valid FIFO entry, or (rf_wen && rf_wsel==rsel1)).
  - pend2: same as pend1, using rsel2.
  - pendw = pipe_wsel!=0 && pipe_wsel matches any valid FIFO entry.
  - The decode/hazard logic must stall the pipeline while pendw=1. This prevents an older queued write overwriting a newer pipeline result.
  - The pipeline entry currently in writeback is not included in pend1/pend2; the forwarding logic handles it.
- count: equals the number of valid FIFO entries, 0..DEPTH.

Test Plan:
- Reset then idle: after nRST low for 1 cycle, expect rf_wen=0, count=0, lu_ready=1, pend1=pend2=pendw=0.
- Pipeline only: pipe_wen=1, wsel=5, wdat=0xDEADBEEF in cycle t -> rf_wen=1, rf_wsel=5, rf_wdat=0xDEADBEEF in cycle t+1; pipe_wsel=0 -> rf_wen=0.
- Priority and drain:
  - Push lu writes r8=0x11, then r9=0x22.
  - Hold pipe_wen=1 (r3) for 3 cycles -> only r3 writes issue; count=2; pend1=1 for rsel1=8.
  - Drop pipe_wen -> r8 issued, then r9, in consecutive cycles; count reaches 0.
- Full boundary:
  - Push 4 entries with pipe_wen held high -> count=4, lu_ready=0.
  - A 5th lu_valid holds without transfer.
  - Release pipe_wen -> one pop, lu_ready returns 1 the following cycle, and the 5th transfers.
- Wrap-around: 10 alternating push/pop cycles with simultaneous push+pop at count=1 -> data issued in exact push order (values 0x100..0x109); count stays at 1.
- WAW and reset mid-operation:
  - Queue r12, then assert pipe_wsel=12 -> pendw=1.
  - Assert nRST low with 3 entries queued -> next cycle count=0, rf_wen=0, pendw=0, and the queued writes never appear.
